// File: rtl/key_debounce_encoder.sv
// rtl/key_debounce_encoder.sv - push-button synchroniser, per-key debouncer and code encoder
//
// Conditions raw active-low push buttons for the 3-to-8 decoder. Each key is
// synchronised, then debounced on its own, and the result drives a stable
// active-high code. The code is either the debounced levels or a toggle
// register flipped by each press.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous reset, active-low
//   keys_n        raw button inputs, active-low, asynchronous to clk
//   keys          debounced key levels, active-high (1 = pressed)
//   press         one-cycle strobe per key on debounced 0->1
//   release_o     one-cycle strobe per key on debounced 1->0
//   code          registered code for the decoder's active-high input
//   code_changed  one-cycle strobe when code takes a new value

module key_debounce_encoder #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit TOGGLE          = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys_n,
  output logic [N_KEYS-1:0] keys,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] code,
  output logic              code_changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Two-flop synchroniser; reset loads 1s so keys look released.
  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;

  // Debounced state, strobes and code.
  logic [N_KEYS-1:0] keys_q, keys_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] code_q, code_d;
  logic              code_changed_q, code_changed_d;

  // Per-key count of consecutive cycles the synchronised level has
  // disagreed with the debounced level.
  logic [CNT_W-1:0] cnt_q [N_KEYS];
  logic [CNT_W-1:0] cnt_d [N_KEYS];

  // Synchronised, active-high key level.
  logic [N_KEYS-1:0] s;

  always_comb begin
    sync1_d = keys_n;
    sync2_d = sync1_q;
    s       = ~sync2_q;
  end

  always_comb begin
    keys_d    = keys_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (s[i] != keys_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // Disagreement has persisted long enough: adopt the new level
          // and raise the matching strobe on this same edge.
          keys_d[i]    = s[i];
          press_d[i]   = s[i];
          release_d[i] = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
      // Agreement (or a completed flip) leaves cnt_d at zero, so any bounce
      // restarts the full count.
    end
  end

  always_comb begin
    if (TOGGLE) begin
      code_d = code_q ^ press_d;
    end else begin
      code_d = keys_d;
    end
    // Several bits may change on one edge; that is still a single pulse.
    code_changed_d = (code_d != code_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q        <= '1;
      sync2_q        <= '1;
      keys_q         <= '0;
      press_q        <= '0;
      release_q      <= '0;
      code_q         <= '0;
      code_changed_q <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      keys_q         <= keys_d;
      press_q        <= press_d;
      release_q      <= release_d;
      code_q         <= code_d;
      code_changed_q <= code_changed_d;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign keys         = keys_q;
  assign press        = press_q;
  assign release_o    = release_q;
  assign code         = code_q;
  assign code_changed = code_changed_q;

endmodule

// File: tb/tb_key_debounce_encoder.sv
// tb/tb_key_debounce_encoder.sv - self-checking bench for key_debounce_encoder

module tb_key_debounce_encoder;

  localparam int NK = 3;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [NK-1:0] keys_n;

  logic [NK-1:0] keys, press, rel, code;
  logic          cc;
  logic [NK-1:0] lkeys, lpress, lrel, lcode;
  logic          lcc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_debounce_encoder #(.N_KEYS(NK), .DEBOUNCE_CYCLES(D), .TOGGLE(1'b1)) u_tog (
    .clk(clk), .rst_n(rst_n), .keys_n(keys_n), .keys(keys), .press(press),
    .release_o(rel), .code(code), .code_changed(cc)
  );

  key_debounce_encoder #(.N_KEYS(NK), .DEBOUNCE_CYCLES(D), .TOGGLE(1'b0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .keys_n(keys_n), .keys(lkeys), .press(lpress),
    .release_o(lrel), .code(lcode), .code_changed(lcc)
  );

  // Reference model: a key's debounced level flips once its last D
  // synchronised samples all disagree with it. Samples reach the debouncer
  // two edges after the raw input is sampled.
  logic [NK-1:0] raw_hist[$];
  logic [NK-1:0] win[$];
  logic [NK-1:0] m_keys, m_press, m_rel, m_code, m_s, m_nk, m_ncode;
  logic          m_cc, m_lcc, m_all;

  always @(posedge clk) begin
    if (!rst_n) begin
      raw_hist = '{3'b111, 3'b111};
      win      = {};
      m_keys = '0; m_press = '0; m_rel = '0; m_code = '0; m_cc = 1'b0; m_lcc = 1'b0;
    end else begin
      m_s = ~raw_hist[0];
      void'(raw_hist.pop_front());
      raw_hist.push_back(keys_n);
      win.push_back(m_s);
      if (win.size() > D) void'(win.pop_front());
      m_nk = m_keys;
      if (win.size() == D) begin
        for (int i = 0; i < NK; i++) begin
          m_all = 1'b1;
          for (int j = 0; j < D; j++) if (win[j][i] == m_keys[i]) m_all = 1'b0;
          if (m_all) m_nk[i] = ~m_keys[i];
        end
      end
      m_press = m_nk & ~m_keys;
      m_rel   = ~m_nk & m_keys;
      m_lcc   = (m_nk != m_keys);
      m_ncode = m_code ^ m_press;
      m_cc    = (m_ncode != m_code);
      m_code  = m_ncode;
      m_keys  = m_nk;
    end
  end

  logic [25:0] obs, mdl;
  assign obs = {keys, press, rel, code, cc, lkeys, lpress, lrel, lcode, lcc};
  assign mdl = {m_keys, m_press, m_rel, m_code, m_cc, m_keys, m_press, m_rel, m_keys, m_lcc};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst_n = 1'b0; keys_n = 3'b000;
    for (int n = 1; n <= 5; n++) begin
      tick();
      n_cmp++;
      if ({keys, press, rel, code, cc, lkeys, lcode, lcc} !== 20'h0) begin
        n_bad++; $display("FAIL reset_outputs cycle %0d got %h want 0", n, {keys, press, rel, code, cc, lkeys, lcode, lcc});
      end
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (cc) pulses++;
      n_cmp++;
      if (obs !== mdl) begin n_bad++; $display("FAIL reset_model edge %0d got %h want %h", n, obs, mdl); end
      if (n == 9) begin
        n_cmp++;
        if (keys !== 3'b000) begin n_bad++; $display("FAIL reset_early keys got %b want 000", keys); end
      end
      if (n == 10) begin
        n_cmp++;
        if ({keys, press, code, cc} !== {3'b111, 3'b111, 3'b111, 1'b1}) begin
          n_bad++; $display("FAIL reset_edge10 got %b want 1111111111", {keys, press, code, cc});
        end
      end
      if (n == 11) begin
        n_cmp++;
        if ({press, cc} !== 4'b0000) begin n_bad++; $display("FAIL reset_strobe_len got %b want 0000", {press, cc}); end
      end
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL reset_cc_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_clean_press();
    rst_n = 1'b0; keys_n = 3'b111;
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    keys_n = 3'b110;
    for (int n = 1; n <= 20; n++) begin
      tick();
      n_cmp++;
      if (obs !== mdl) begin n_bad++; $display("FAIL press_model edge %0d got %h want %h", n, obs, mdl); end
      if (n == 10) begin
        n_cmp++;
        if ({keys, press, code, cc} !== {3'b001, 3'b001, 3'b001, 1'b1}) begin
          n_bad++; $display("FAIL press_edge10 got %b want 0010010011", {keys, press, code, cc});
        end
      end
      if (n == 11) begin
        n_cmp++;
        if (press !== 3'b000) begin n_bad++; $display("FAIL press_one_cycle got %b want 000", press); end
      end
    end
    keys_n = 3'b111;
    for (int n = 1; n <= 12; n++) begin
      tick();
      n_cmp++;
      if (obs !== mdl) begin n_bad++; $display("FAIL release_model edge %0d got %h want %h", n, obs, mdl); end
      if (n == 10) begin
        n_cmp++;
        if ({keys, rel, code, cc} !== {3'b000, 3'b001, 3'b001, 1'b0}) begin
          n_bad++; $display("FAIL release_edge10 got %b want 0000010010", {keys, rel, code, cc});
        end
      end
    end
  endtask

  task automatic test_glitch();
    keys_n = 3'b101;
    for (int n = 1; n <= 19; n++) begin
      if (n == 8) keys_n = 3'b111;
      tick();
      n_cmp++;
      if ({keys, press, rel, code, cc} !== {3'b000, 3'b000, 3'b000, 3'b001, 1'b0}) begin
        n_bad++; $display("FAIL glitch_stable cycle %0d got %b want 0000000000010", n, {keys, press, rel, code, cc});
      end
      n_cmp++;
      if (obs !== mdl) begin n_bad++; $display("FAIL glitch_model cycle %0d got %h want %h", n, obs, mdl); end
    end
  endtask

  task automatic test_chatter();
    int lens[4] = '{3, 1, 2, 1};
    int npress = 0, nrel = 0, first = -1;
    for (int k = 0; k < 4; k++) begin
      keys_n = (k % 2 == 0) ? 3'b011 : 3'b111;
      for (int n = 0; n < lens[k]; n++) begin
        tick();
        if (press[2]) npress++;
        if (rel[2]) nrel++;
        n_cmp++;
        if (obs !== mdl) begin n_bad++; $display("FAIL chatter_model got %h want %h", obs, mdl); end
      end
    end
    keys_n = 3'b011;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (press[2]) begin npress++; if (first < 0) first = n; end
      if (rel[2]) nrel++;
      n_cmp++;
      if (obs !== mdl) begin n_bad++; $display("FAIL chatter_model_steady got %h want %h", obs, mdl); end
    end
    n_cmp++;
    if (npress != 1 || first != 10 || nrel != 0) begin
      n_bad++; $display("FAIL chatter_single_press got presses=%0d at=%0d releases=%0d want 1 at 10 and 0", npress, first, nrel);
    end
    keys_n = 3'b111;
    repeat (12) tick();
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    rst_n = 1'b0; keys_n = 3'b111;
    tick(); tick();
    rst_n = 1'b1;
    keys_n = 3'b110;
    repeat (12) tick();
    keys_n = 3'b111;
    repeat (12) tick();
    n_cmp++;
    if (code !== 3'b001) begin n_bad++; $display("FAIL simul_start code got %b want 001", code); end
    keys_n = 3'b010;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (cc) pulses++;
      n_cmp++;
      if (obs !== mdl) begin n_bad++; $display("FAIL simul_model edge %0d got %h want %h", n, obs, mdl); end
      if (n == 10) begin
        n_cmp++;
        if ({code, press, cc} !== {3'b100, 3'b101, 1'b1}) begin
          n_bad++; $display("FAIL simul_edge10 got %b want 1001011", {code, press, cc});
        end
      end
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL simul_cc_pulses got %0d want 1", pulses); end
    keys_n = 3'b111;
    repeat (12) tick();
  endtask

  task automatic test_reset_midcount();
    int npress = 0;
    keys_n = 3'b101;
    repeat (7) tick();
    rst_n = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      n_cmp++;
      if ({keys, press, code, cc} !== 10'h0) begin
        n_bad++; $display("FAIL midreset_outputs got %b want 0", {keys, press, code, cc});
      end
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (press[1]) npress++;
      n_cmp++;
      if (obs !== mdl) begin n_bad++; $display("FAIL midreset_model edge %0d got %h want %h", n, obs, mdl); end
      if (n == 9 || n == 10) begin
        n_cmp++;
        if (keys[1] !== (n == 10)) begin
          n_bad++; $display("FAIL midreset_latency edge %0d keys1 got %b want %0d", n, keys[1], (n == 10));
        end
      end
    end
    n_cmp++;
    if (npress != 1) begin n_bad++; $display("FAIL midreset_press_count got %0d want 1", npress); end
    keys_n = 3'b111;
    repeat (12) tick();
  endtask

  task automatic test_random();
    int hold[NK] = '{0, 0, 0};
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          keys_n[i] = ~keys_n[i];
          hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : $urandom_range(6, 24);
        end else begin
          hold[i]--;
        end
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      n_cmp++;
      if (obs !== mdl) begin n_bad++; $display("FAIL random_model cycle %0d got %h want %h", n, obs, mdl); end
      n_cmp++;
      if (lcode !== lkeys) begin n_bad++; $display("FAIL level_code_eq_keys cycle %0d got %b want %b", n, lcode, lkeys); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    keys_n = 3'b111;
    test_reset();
    test_clean_press();
    test_glitch();
    test_chatter();
    test_simultaneous();
    test_reset_midcount();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
